// File: rtl/cache_mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter onto one memory bus; grant held for a whole read burst or write.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to port 1.
module cache_mem_arbiter #(
    parameter int WORDSIZE      = 64,
    parameter int TAGWIDTH      = 13,
    parameter int LOGLINEOFFSET = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               c_reqcyc,
    input  logic [1:0][WORDSIZE-1:0] c_req,
    input  logic [1:0][TAGWIDTH-1:0] c_reqtag,
    output logic [1:0]               c_reqack,
    output logic [1:0]               c_respcyc,
    output logic [WORDSIZE-1:0]      c_resp,
    output logic [TAGWIDTH-1:0]      c_resptag,
    input  logic [1:0]               c_respack,
    output logic                     m_reqcyc,
    output logic [WORDSIZE-1:0]      m_req,
    output logic [TAGWIDTH-1:0]      m_reqtag,
    input  logic                     m_reqack,
    input  logic                     m_respcyc,
    input  logic [WORDSIZE-1:0]      m_resp,
    input  logic [TAGWIDTH-1:0]      m_resptag,
    output logic                     m_respack,
    output logic                     busy
);
    localparam int CW = LOGLINEOFFSET + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'((1 << LOGLINEOFFSET) - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  m_reqcyc_q, m_reqcyc_d;
    logic [WORDSIZE-1:0]   m_req_q, m_req_d;
    logic [TAGWIDTH-1:0]   m_reqtag_q, m_reqtag_d;
    logic                  win;
    logic                  beat;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    always_comb begin
        win = c_reqcyc[1];
        if (&c_reqcyc) win = ~last_q;
    end

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && |c_reqcyc) last_d = win;
    end

    always_ff @(posedge clk) begin
        if (reset) last_q <= 1'b1;
        else       last_q <= last_d;
    end
`else
    // Port 1 wins whenever it is requesting.
    always_comb win = c_reqcyc[1];
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        m_reqcyc_d = m_reqcyc_q;
        m_req_d    = m_req_q;
        m_reqtag_d = m_reqtag_q;
        c_reqack   = '0;
        c_respcyc  = '0;
        c_resp     = '0;
        c_resptag  = '0;
        m_respack  = 1'b0;
        beat       = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|c_reqcyc && !reset) begin
                    grant_d       = win;
                    rd_d          = c_reqtag[win][TAGWIDTH-1];
                    m_req_d       = c_req[win];
                    m_reqtag_d    = c_reqtag[win];
                    m_reqcyc_d    = 1'b1;
                    c_reqack[win] = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (m_reqack) begin
                    m_reqcyc_d = 1'b0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                // Beats seen during a reset cycle are dropped, not acknowledged.
                if (!reset) begin
                    c_respcyc[grant_q] = m_respcyc;
                    c_resp             = m_resp;
                    c_resptag          = m_resptag;
                    m_respack          = c_respack[grant_q];
                    beat               = m_respcyc & c_respack[grant_q];
                    if (beat) begin
                        cnt_d = cnt_q + CW'(1);
                        if (!rd_q || cnt_q == LAST_BEAT) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            rd_q       <= 1'b0;
            cnt_q      <= '0;
            m_reqcyc_q <= 1'b0;
            m_req_q    <= '0;
            m_reqtag_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            m_reqcyc_q <= m_reqcyc_d;
            m_req_q    <= m_req_d;
            m_reqtag_q <= m_reqtag_d;
        end
    end

    assign m_reqcyc = m_reqcyc_q;
    assign m_req    = m_req_q;
    assign m_reqtag = m_reqtag_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed + randomized bench for cache_mem_arbiter with a transaction-level reference model.
module tb_cache_mem_arbiter;
    localparam int W = 64;
    localparam int T = 13;

    logic                clk = 1'b0;
    logic                reset;
    logic [1:0]          c_reqcyc;
    logic [1:0][W-1:0]   c_req;
    logic [1:0][T-1:0]   c_reqtag;
    logic [1:0]          c_reqack;
    logic [1:0]          c_respcyc;
    logic [W-1:0]        c_resp;
    logic [T-1:0]        c_resptag;
    logic [1:0]          c_respack;
    logic                m_reqcyc;
    logic [W-1:0]        m_req;
    logic [T-1:0]        m_reqtag;
    logic                m_reqack;
    logic                m_respcyc;
    logic [W-1:0]        m_resp;
    logic [T-1:0]        m_resptag;
    logic                m_respack;
    logic                busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: outstanding requests and last port granted.
    logic [1:0]   pend = 2'b00;
    logic [W-1:0] exp_req [2];
    logic [T-1:0] exp_tag [2];
    int           last_gnt = 1;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.WORDSIZE(W), .TAGWIDTH(T), .LOGLINEOFFSET(3)) dut (
        .clk(clk), .reset(reset),
        .c_reqcyc(c_reqcyc), .c_req(c_req), .c_reqtag(c_reqtag), .c_reqack(c_reqack),
        .c_respcyc(c_respcyc), .c_resp(c_resp), .c_resptag(c_resptag), .c_respack(c_respack),
        .m_reqcyc(m_reqcyc), .m_req(m_req), .m_reqtag(m_reqtag), .m_reqack(m_reqack),
        .m_respcyc(m_respcyc), .m_resp(m_resp), .m_resptag(m_resptag), .m_respack(m_respack),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [1:0] m);
        if (m == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
            return (last_gnt == 0) ? 1 : 0;
`else
            return 1;
`endif
        end
        return m[1] ? 1 : 0;
    endfunction

    task automatic post(input int p, input bit rd);
        exp_req[p]  = {$urandom, $urandom};
        exp_tag[p]  = {rd, 12'($urandom)};
        c_req[p]    = exp_req[p];
        c_reqtag[p] = exp_tag[p];
        c_reqcyc[p] = 1'b1;
        pend[p]     = 1'b1;
    endtask

    // Entered at posedge+1 of a cycle in which the DUT is IDLE with requests pending.
    task automatic serve(input logic [W-1:0] base, input bit bp, input int abort_at);
        int p, n, b, stalls, guard, d;
        bit ack;
        logic [T-1:0] rt;
        p = pick(pend);
        last_gnt = p;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_respcyc", c_respcyc, 0);
        chk("idle_respack", m_respack, 0);
        chk("reqack", c_reqack, 2'b01 << p);
        @(posedge clk); #1;
        c_reqcyc[p] = 1'b0;
        pend[p]     = 1'b0;
        m_respcyc   = 1'b1;
        m_resp      = {$urandom, $urandom};
        c_respack   = 2'b11;
        @(negedge clk);
        chk("issue_reqcyc", m_reqcyc, 1);
        chk("issue_req", m_req, exp_req[p]);
        chk("issue_reqtag", m_reqtag, exp_tag[p]);
        chk("issue_busy", busy, 1);
        chk("issue_noack", c_reqack, 0);
        chk("issue_respack", m_respack, 0);
        chk("issue_respcyc", c_respcyc, 0);
        d = $urandom_range(0, 2);
        repeat (d) begin
            @(posedge clk); #1;
            m_respcyc = 1'b0;
            @(negedge clk);
            chk("hold_reqcyc", m_reqcyc, 1);
            chk("hold_req", m_req, exp_req[p]);
        end
        @(posedge clk); #1;
        m_respcyc = 1'b0;
        m_reqack  = 1'b1;
        @(negedge clk);
        chk("ackcyc_reqcyc", m_reqcyc, 1);
        @(posedge clk); #1;
        m_reqack = 1'b0;
        n = exp_tag[p][T-1] ? 8 : 1;
        b = 0; stalls = 0; guard = 0;
        while (b < n && guard < 64) begin
            if (guard != 0) begin @(posedge clk); #1; end
            guard++;
            if (bp && b == 3 && stalls < 2) begin ack = 1'b0; stalls++; end
            else if (bp)                     ack = 1'b1;
            else                             ack = ($urandom_range(0, 3) != 0);
            rt             = T'($urandom);
            m_respcyc      = 1'b1;
            m_resp         = base + W'(b);
            m_resptag      = rt;
            c_respack[p]   = ack;
            c_respack[1-p] = ~ack;
            if (b == abort_at) reset = 1'b1;
            @(negedge clk);
            if (b == abort_at) begin
                chk("abort_respack", m_respack, 0);
                @(posedge clk); #1;
                reset     = 1'b0;
                m_respcyc = 1'b0;
                c_respack = 2'b00;
                last_gnt  = 1;
                return;
            end
            chk("beat_respcyc", c_respcyc, 2'b01 << p);
            chk("beat_resp", c_resp, base + W'(b));
            chk("beat_resptag", c_resptag, rt);
            chk("beat_respack", m_respack, ack);
            chk("beat_busy", busy, 1);
            chk("beat_reqcyc", m_reqcyc, 0);
            if (ack) b++;
        end
        chk("beat_total", b, n);
        // Stray beat presented in the following IDLE cycle must be ignored.
        @(posedge clk); #1;
        m_respcyc = 1'b1;
        m_resp    = {$urandom, $urandom};
        c_respack = 2'b11;
    endtask

    task automatic drain();
        int g = 0;
        while (pend != 2'b00 && g < 8) begin
            serve({$urandom, $urandom}, 1'b0, -1);
            g++;
        end
        chk("drained", pend, 0);
    endtask

    initial begin
        reset = 1'b1; c_reqcyc = '0; c_req = '0; c_reqtag = '0; c_respack = '0;
        m_reqack = 1'b0; m_respcyc = 1'b0; m_resp = '0; m_resptag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_reqack", c_reqack, 0);
        chk("rst_reqcyc", m_reqcyc, 0);
        chk("rst_req", m_req, 0);
        chk("rst_reqtag", m_reqtag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_respcyc", c_respcyc, 0);
        chk("rst_respack", m_respack, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single read on port 0 with data 0xA0..0xA7.
        post(0, 1'b1);
        exp_req[0] = 64'h1000;
        c_req[0]   = 64'h1000;
        serve(64'hA0, 1'b0, -1);

        // Simultaneous requests: three ties in a row, then drain.
        for (int i = 0; i < 3; i++) begin
            if (!pend[0]) post(0, 1'($urandom));
            if (!pend[1]) post(1, 1'($urandom));
            serve({$urandom, $urandom}, 1'b0, -1);
        end
        drain();

        // Write on port 1, then a tie whose loser is granted in the first IDLE cycle.
        post(1, 1'b0);
        serve({$urandom, $urandom}, 1'b0, -1);
        post(0, 1'b1);
        post(1, 1'b0);
        drain();

        // Backpressure mid-burst.
        post(0, 1'b1);
        serve({$urandom, $urandom}, 1'b1, -1);

        // Reset at beat 4 of a read, then a fresh full burst.
        post(1, 1'b1);
        serve({$urandom, $urandom}, 1'b0, 4);
        @(negedge clk);
        chk("post_abort_busy", busy, 0);
        chk("post_abort_reqcyc", m_reqcyc, 0);
        @(posedge clk); #1;
        post(1, 1'b1);
        serve({$urandom, $urandom}, 1'b0, -1);

        // Randomized traffic.
        for (int i = 0; i < 12; i++) begin
            if (!pend[0] && $urandom_range(0, 1) == 1) post(0, 1'($urandom));
            if (!pend[1] && (pend == 2'b00 || $urandom_range(0, 1) == 1)) post(1, 1'($urandom));
            serve({$urandom, $urandom}, 1'($urandom), -1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
